// File: rtl/aes_host_pkg.sv
// Shared definitions for the AES host sequencer: FSM state encoding and default sizes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package aes_host_pkg;

    localparam int DATA_W_DEF = 128;
    localparam int DEPTH_DEF  = 4;
    localparam int CNT_W_DEF  = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SEND  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/aes_sync_fifo.sv
// Synchronous FIFO of DEPTH entries, used for both the host input and result output buffers.
// Latency: a pushed word is visible at rd_data the cycle after the push; rd_data is the head, read combinationally.
// Backpressure: wr_en is ignored when full unless a pop happens in the same cycle.
// Ports: clk, reset (sync, active-high); wr_en/wr_data push side; rd_en/rd_data pop side; full, empty status.
module aes_sync_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_wr;
    logic             do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop frees the slot at the same edge, so push-while-full succeeds when paired with a pop.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/aes_host_seq.sv
// Host-side sequencer feeding blocks from an input FIFO to an AES core and buffering results in an output FIFO.
// Latency: start -> first core strobe 2 cycles; core result -> out_valid 1 cycle, core_data_out_stb 1 cycle.
// Backpressure: in_ready drops when the input FIFO is full; core_ready stalls SEND; output FIFO full drops results and sets overflow.
// Ports: clk, reset (sync, active-high); start/num_blocks run control; in_* host write port; out_* result read port;
//        core_* AES core handshake; busy/done/overflow status; sent_count/recv_count run counters.
// Optional: define AES_HOST_SEQ_KEYACK_EN to acknowledge core_key_change_rq on core_key_ch; otherwise core_key_ch is 0.
module aes_host_seq
    import aes_host_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_blocks,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              core_ready,
    output logic              core_data_in_stb,
    output logic [DATA_W-1:0] core_data_in,
    input  logic              core_data_valid,
    input  logic [DATA_W-1:0] core_data_out,
    output logic              core_data_out_stb,
    input  logic              core_key_change_rq,
    output logic              core_key_ch,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [CNT_W-1:0]  sent_count,
    output logic [CNT_W-1:0]  recv_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   num_blocks_q;
    logic [CNT_W-1:0]   sent_inc_val;
    logic [CNT_W-1:0]   recv_inc_val;
    logic               start_go;
    logic               pop_in;
    logic               sent_inc;

    logic               in_full;
    logic               in_empty;
    logic [DATA_W-1:0]  in_head;
    logic               out_full;
    logic               out_empty;
    logic [DATA_W-1:0]  out_head;
    logic               out_pop;
    logic               cap_push;
    logic               cap_drop;

    // ---------------- buffers ----------------
    assign in_ready = !in_full;

    aes_sync_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_in_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (in_valid && in_ready),
        .wr_data (in_data),
        .rd_en   (pop_in),
        .rd_data (in_head),
        .full    (in_full),
        .empty   (in_empty)
    );

    assign out_valid = !out_empty;
    assign out_pop   = out_valid && out_ready;
    // Head is forced to zero when empty so the port reads 0 out of reset.
    assign out_data  = out_valid ? out_head : '0;

    // A result arriving while full still fits if the host pops in the same cycle.
    assign cap_push = core_data_valid && (!out_full || out_pop);
    assign cap_drop = core_data_valid && !cap_push;

    aes_sync_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_out_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (cap_push),
        .wr_data (core_data_out),
        .rd_en   (out_pop),
        .rd_data (out_head),
        .full    (out_full),
        .empty   (out_empty)
    );

    // ---------------- counters (saturating) ----------------
    assign sent_inc_val = (sent_count == '1) ? sent_count : sent_count + CNT_ONE;
    assign recv_inc_val = (recv_count == '1) ? recv_count : recv_count + CNT_ONE;

    // ---------------- FSM ----------------
    always_comb begin
        state_nxt = state;
        start_go  = 1'b0;
        pop_in    = 1'b0;
        sent_inc  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    start_go  = 1'b1;
                    state_nxt = (num_blocks == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (!in_empty && (sent_count < num_blocks_q)) begin
                    pop_in    = 1'b1;
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (core_ready) begin
                    sent_inc  = 1'b1;
                    state_nxt = (sent_inc_val == num_blocks_q) ? ST_DRAIN : ST_FETCH;
                end
            end
            ST_DRAIN: begin
                // >= rather than == so a surplus result from the core cannot strand the run.
                if (recv_count >= num_blocks_q) state_nxt = ST_DONE;
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= ST_IDLE;
            num_blocks_q      <= '0;
            sent_count        <= '0;
            recv_count        <= '0;
            overflow          <= 1'b0;
            core_data_in      <= '0;
            core_data_out_stb <= 1'b0;
        end else begin
            state             <= state_nxt;
            core_data_out_stb <= cap_push;

            if (start_go) begin
                num_blocks_q <= num_blocks;
                sent_count   <= '0;
            end else if (sent_inc) begin
                sent_count   <= sent_inc_val;
            end

            if (pop_in) core_data_in <= in_head;

            // A result landing on the start cycle belongs to the new run.
            if (start_go)      recv_count <= cap_push ? CNT_ONE : '0;
            else if (cap_push) recv_count <= recv_inc_val;

            if (start_go)      overflow <= cap_drop;
            else if (cap_drop) overflow <= 1'b1;
        end
    end

    assign core_data_in_stb = (state == ST_SEND);
    assign busy             = (state == ST_FETCH) || (state == ST_SEND) || (state == ST_DRAIN);
    assign done             = (state == ST_DONE);

    // ---------------- key change acknowledge ----------------
`ifdef AES_HOST_SEQ_KEYACK_EN
    logic key_ch_q;

    // Blocking re-arm while the ack is high turns a held request into a 1/0 toggle.
    always_ff @(posedge clk) begin
        if (reset) key_ch_q <= 1'b0;
        else       key_ch_q <= core_key_change_rq && !key_ch_q;
    end

    assign core_key_ch = key_ch_q;
`else
    logic key_rq_unused;

    assign key_rq_unused = core_key_change_rq;
    assign core_key_ch   = 1'b0;
`endif

endmodule

// File: tb/tb_aes_host_seq.sv
// Directed bench for aes_host_seq with queue scoreboards on the core-input and result paths.
// Latency: n/a.
// Backpressure: exercised via core_ready stalls and out_ready held low.
module tb_aes_host_seq;

    localparam int DATA_W = 128;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [CNT_W-1:0]  num_blocks;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              core_ready;
    logic              core_data_in_stb;
    logic [DATA_W-1:0] core_data_in;
    logic              core_data_valid;
    logic [DATA_W-1:0] core_data_out;
    logic              core_data_out_stb;
    logic              core_key_change_rq;
    logic              core_key_ch;
    logic              busy;
    logic              done;
    logic              overflow;
    logic [CNT_W-1:0]  sent_count;
    logic [CNT_W-1:0]  recv_count;

    int checks = 0;
    int errors = 0;
    int hs_seen = 0;
    int out_stb_seen = 0;
    int exp_out_stb = 0;

    logic [DATA_W-1:0] in_q[$];
    logic [DATA_W-1:0] out_q[$];

    always #5 clk = ~clk;

    aes_host_seq #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .num_blocks         (num_blocks),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_data            (in_data),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_data           (out_data),
        .core_ready         (core_ready),
        .core_data_in_stb   (core_data_in_stb),
        .core_data_in       (core_data_in),
        .core_data_valid    (core_data_valid),
        .core_data_out      (core_data_out),
        .core_data_out_stb  (core_data_out_stb),
        .core_key_change_rq (core_key_change_rq),
        .core_key_ch        (core_key_ch),
        .busy               (busy),
        .done               (done),
        .overflow           (overflow),
        .sent_count         (sent_count),
        .recv_count         (recv_count)
    );

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Core-side monitor: every accepted block must match the next block written by the host.
    always @(negedge clk) begin
        if (!reset && core_data_in_stb && core_ready) begin
            hs_seen++;
            if (in_q.size() == 0) check("core_in_unexpected", core_data_in, '1);
            else                  check("core_in_data", core_data_in, in_q.pop_front());
        end
        if (!reset && core_data_out_stb) out_stb_seen++;
    end

    // Host-side monitor: every result read must match the next captured core result.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (out_q.size() == 0) check("out_unexpected", out_data, '1);
            else                   check("out_data", out_data, out_q.pop_front());
        end
    end

    initial begin
        int n;
        logic [DATA_W-1:0] stall_val;

        reset = 1'b1;
        start = 1'b0;
        num_blocks = '0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        core_ready = 1'b0;
        core_data_valid = 1'b0;
        core_data_out = '0;
        core_key_change_rq = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        // ---- reset state ----
        @(negedge clk);
        check("rst_stb", core_data_in_stb, 0);
        check("rst_core_in", core_data_in, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ovf", overflow, 0);
        check("rst_sent", sent_count, 0);
        check("rst_recv", recv_count, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_key_ch", core_key_ch, 0);

        // ---- three-block run with core always ready ----
        for (int k = 1; k <= 3; k++) begin
            tick();
            in_valid = 1'b1;
            in_data  = DATA_W'(k);
            in_q.push_back(DATA_W'(k));
        end
        tick();
        in_valid   = 1'b0;
        core_ready = 1'b1;
        start      = 1'b1;
        num_blocks = 8'd3;
        tick();
        start = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!(sent_count == 3 && !core_data_in_stb) && n < 40);
        check("run3_drain_reached", n < 40, 1);
        check("run3_sent", sent_count, 3);
        check("run3_busy_drain", busy, 1);
        check("run3_hs", hs_seen, 3);
        for (int k = 1; k <= 3; k++) begin
            tick();
            core_data_valid = 1'b1;
            core_data_out   = DATA_W'(32'hA0 + k);
            out_q.push_back(DATA_W'(32'hA0 + k));
            tick();
            core_data_valid = 1'b0;
        end
        exp_out_stb += 3;
        n = 0;
        do begin @(negedge clk); n++; end while (!done && n < 40);
        check("run3_done_seen", done, 1);
        check("run3_recv", recv_count, 3);
        tick();
        @(negedge clk);
        check("run3_done_one_cycle", done, 0);
        check("run3_idle_busy", busy, 0);
        tick();
        out_ready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (out_valid && n < 40);
        tick();
        out_ready = 1'b0;
        check("run3_out_drained", out_q.size(), 0);

        // ---- core stalls 10 cycles in SEND ----
        stall_val = {4{32'hC0DE_0055}};
        tick();
        core_ready = 1'b0;
        in_valid   = 1'b1;
        in_data    = stall_val;
        in_q.push_back(stall_val);
        tick();
        in_valid   = 1'b0;
        start      = 1'b1;
        num_blocks = 8'd1;
        tick();
        start = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!core_data_in_stb && n < 40);
        for (int i = 0; i < 10; i++) begin
            check("stall_stb", core_data_in_stb, 1);
            check("stall_data", core_data_in, stall_val);
            @(negedge clk);
        end
        check("stall_hs_none", hs_seen, 3);
        tick();
        core_ready = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("stall_stb_drop", core_data_in_stb, 0);
        check("stall_sent", sent_count, 1);
        check("stall_hs_one", hs_seen, 4);
        tick();
        core_data_valid = 1'b1;
        core_data_out   = {4{32'h5A5A_0001}};
        out_q.push_back({4{32'h5A5A_0001}});
        exp_out_stb += 1;
        tick();
        core_data_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!done && n < 40);
        check("stall_done_seen", done, 1);
        tick();
        out_ready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (out_valid && n < 40);
        tick();
        out_ready = 1'b0;

        // ---- empty run ----
        start      = 1'b1;
        num_blocks = 8'd0;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("empty_done", done, 1);
        check("empty_stb", core_data_in_stb, 0);
        check("empty_recv_cleared", recv_count, 0);
        tick();
        @(negedge clk);
        check("empty_done_drop", done, 0);
        check("empty_hs_none", hs_seen, 4);

        // ---- output FIFO overflow: 5 results into 4 entries ----
        for (int k = 0; k < 5; k++) begin
            tick();
            core_data_valid = 1'b1;
            core_data_out   = DATA_W'(32'hB0 + k);
            if (k < 4) out_q.push_back(DATA_W'(32'hB0 + k));
        end
        tick();
        core_data_valid = 1'b0;
        exp_out_stb += 4;
        @(negedge clk);
        check("ovf_flag", overflow, 1);
        check("ovf_recv", recv_count, 4);
        check("ovf_out_valid", out_valid, 1);
        check("ovf_stb_count", out_stb_seen, exp_out_stb);

        // Clear sticky overflow with an empty run, then push and pop together on a full FIFO.
        tick();
        start      = 1'b1;
        num_blocks = 8'd0;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("ovf_cleared", overflow, 0);
        tick();
        core_data_valid = 1'b1;
        core_data_out   = DATA_W'(32'hC0);
        out_q.push_back(DATA_W'(32'hC0));
        out_ready = 1'b1;
        exp_out_stb += 1;
        tick();
        core_data_valid = 1'b0;
        @(negedge clk);
        check("full_pushpop_ovf", overflow, 0);
        check("full_pushpop_recv", recv_count, 1);
        n = 0;
        do begin @(negedge clk); n++; end while (out_valid && n < 40);
        tick();
        out_ready = 1'b0;
        check("ovf_out_drained", out_q.size(), 0);
        check("out_stb_total", out_stb_seen, exp_out_stb);

        // ---- key change acknowledge with request held 6 cycles ----
        core_key_change_rq = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
`ifdef AES_HOST_SEQ_KEYACK_EN
            check("key_ch", core_key_ch, DATA_W'(i % 2));
`else
            check("key_ch", core_key_ch, 0);
`endif
            tick();
        end
        core_key_change_rq = 1'b0;

        // ---- reset while in SEND ----
        core_ready = 1'b0;
        in_valid   = 1'b1;
        in_data    = DATA_W'(32'h77);
        in_q.push_back(DATA_W'(32'h77));
        tick();
        in_valid   = 1'b0;
        start      = 1'b1;
        num_blocks = 8'd2;
        tick();
        start = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!core_data_in_stb && n < 40);
        check("mid_reset_in_send", core_data_in_stb, 1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        in_q.delete();
        @(negedge clk);
        check("mid_reset_stb", core_data_in_stb, 0);
        check("mid_reset_busy", busy, 0);
        check("mid_reset_sent", sent_count, 0);
        check("mid_reset_recv", recv_count, 0);
        check("mid_reset_in_ready", in_ready, 1);
        check("mid_reset_core_in", core_data_in, 0);
        check("mid_reset_out_valid", out_valid, 0);
        repeat (2) tick();
        check("final_hs", hs_seen, 4);
        check("final_in_q", in_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
